seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with a guard (all-off) gap
// after each digit, leading-zero blanking and frame-synchronised data update.
module seg_scan_ctrl #(
    parameter int PRESCALE = 50000,
    parameter int GUARD    = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] dado,
    input  logic        blank_lz,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic        pending,
    output logic        frame_tick
);

    typedef enum logic {
        S_SHOW  = 1'b0,
        S_GUARD = 1'b1
    } state_t;

    localparam bit          NO_GUARD = (GUARD == 0);
    localparam logic [19:0] P_LAST   = 20'(PRESCALE - 1);
    localparam logic [19:0] G_LAST   = NO_GUARD ? 20'd0 : 20'(GUARD - 1);

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [19:0] r_cnt;
    logic [15:0] r_active;
    logic [15:0] r_shadow;
    logic        r_pending;

    logic        w_show_end;
    logic        w_guard_end;
    logic        w_boundary;
    logic        w_upper_zero;
    logic        w_blank;

    assign w_show_end  = (r_state == S_SHOW)  && (r_cnt == P_LAST);
    assign w_guard_end = (r_state == S_GUARD) && (r_cnt == G_LAST);
    // Frame ends on the last cycle spent on digit 3, whichever phase that is.
    assign w_boundary  = (r_idx == 2'd3) && (NO_GUARD ? w_show_end : w_guard_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_SHOW;
            r_idx   <= 2'd0;
            r_cnt   <= 20'd0;
        end else begin
            case (r_state)
                S_SHOW: begin
                    if (w_show_end) begin
                        r_cnt <= 20'd0;
                        if (NO_GUARD) begin
                            r_idx <= r_idx + 2'd1;
                        end else begin
                            r_state <= S_GUARD;
                        end
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
                S_GUARD: begin
                    if (w_guard_end) begin
                        r_state <= S_SHOW;
                        r_idx   <= r_idx + 2'd1;
                        r_cnt   <= 20'd0;
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
                default: begin
                    r_state <= S_SHOW;
                    r_idx   <= 2'd0;
                    r_cnt   <= 20'd0;
                end
            endcase
        end
    end

    // Display data only moves at the boundary so one frame never mixes values;
    // a load on the boundary itself bypasses the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= 16'h0000;
            r_shadow  <= 16'h0000;
            r_pending <= 1'b0;
        end else if (w_boundary) begin
            if (load) begin
                r_active  <= dado;
                r_shadow  <= dado;
                r_pending <= 1'b0;
            end else if (r_pending) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end
        end else if (load) begin
            r_shadow  <= dado;
            r_pending <= 1'b1;
        end
    end

    always_comb begin
        w_upper_zero = 1'b0;
        case (r_idx)
            2'd1:    w_upper_zero = (r_active[15:4]  == 12'h000);
            2'd2:    w_upper_zero = (r_active[15:8]  == 8'h00);
            2'd3:    w_upper_zero = (r_active[15:12] == 4'h0);
            default: w_upper_zero = 1'b0;
        endcase
    end

    assign w_blank    = blank_lz && w_upper_zero;
    assign bcd_out    = r_active[{r_idx, 2'b00} +: 4];
    assign an         = ((r_state == S_GUARD) || w_blank) ? 4'b1111 : ~(4'b0001 << r_idx);
    assign pending    = r_pending;
    assign frame_tick = w_boundary;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with PRESCALE=4, GUARD=2 (24-cycle frame).
module tb_seg_scan_ctrl;

  localparam int P = 4;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] dado;
  logic        blank_lz;
  logic [3:0]  bcd_out;
  logic [3:0]  an;
  logic        pending;
  logic        frame_tick;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  seg_scan_ctrl #(.PRESCALE(P), .GUARD(G)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .dado       (dado),
    .blank_lz   (blank_lz),
    .bcd_out    (bcd_out),
    .an         (an),
    .pending    (pending),
    .frame_tick (frame_tick)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

  // Reference: a cycle c after reset release sits at position c%24 of the frame,
  // six cycles per digit (4 lit, 2 guard).
  function automatic logic [3:0] exp_an(int c, logic [15:0] act, logic blz);
    int pos;
    int k;
    logic [15:0] upper;
    pos = c % 24;
    k   = pos / 6;
    if ((pos % 6) >= 4) return 4'b1111;
    upper = act >> (4 * k);
    if (blz && (k > 0) && (upper == 16'h0000)) return 4'b1111;
    return ~(4'b0001 << k);
  endfunction

  function automatic logic [3:0] exp_bcd(int c, logic [15:0] act);
    int k;
    logic [15:0] sh;
    k  = (c % 24) / 6;
    sh = act >> (4 * k);
    return sh[3:0];
  endfunction

  function automatic logic exp_tick(int c);
    return ((c % 24) == 23);
  endfunction

  // driver tasks
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    load     = 1'b0;
    dado     = 16'h0000;
    blank_lz = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_reset();
    load = 1'b0; dado = 16'h0000; blank_lz = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (an !== 4'b1110 || bcd_out !== 4'h0 || pending !== 1'b0 || frame_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async an=%b bcd=%h pend=%b tick=%b exp an=1110 bcd=0 pend=0 tick=0",
               an, bcd_out, pending, frame_tick);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    #1;
    tests_run++;
    if (an !== 4'b1110 || bcd_out !== 4'h0 || pending !== 1'b0 || frame_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release an=%b bcd=%h pend=%b tick=%b exp an=1110 bcd=0 pend=0 tick=0",
               an, bcd_out, pending, frame_tick);
    end
  endtask

  task automatic test_scan();
    do_reset();
    for (int i = 0; i < 48; i++) begin
      tests_run++;
      if (an !== exp_an(cyc, 16'h0000, 1'b0)) begin
        tests_failed++;
        $display("FAIL scan_an cyc=%0d got=%b exp=%b", cyc, an, exp_an(cyc, 16'h0000, 1'b0));
      end
      tests_run++;
      if (bcd_out !== 4'h0 || pending !== 1'b0) begin
        tests_failed++;
        $display("FAIL scan_bcd_pend cyc=%0d bcd=%h pend=%b exp bcd=0 pend=0", cyc, bcd_out, pending);
      end
      tests_run++;
      if (frame_tick !== exp_tick(cyc)) begin
        tests_failed++;
        $display("FAIL scan_tick cyc=%0d got=%b exp=%b", cyc, frame_tick, exp_tick(cyc));
      end
      tick();
    end
  endtask

  task automatic test_load();
    logic [15:0] act;
    logic        pend;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      act  = (cyc >= 24) ? 16'h1234 : 16'h0000;
      pend = (cyc >= 6) && (cyc <= 23);
      tests_run++;
      if (pending !== pend) begin
        tests_failed++;
        $display("FAIL load_pending cyc=%0d got=%b exp=%b", cyc, pending, pend);
      end
      tests_run++;
      if (bcd_out !== exp_bcd(cyc, act) || an !== exp_an(cyc, act, 1'b0)) begin
        tests_failed++;
        $display("FAIL load_disp cyc=%0d bcd=%h an=%b exp bcd=%h an=%b",
                 cyc, bcd_out, an, exp_bcd(cyc, act), exp_an(cyc, act, 1'b0));
      end
      if (cyc == 5) begin
        load = 1'b1;
        dado = 16'h1234;
      end
      tick();
      load = 1'b0;
    end
  endtask

  // Continues from test_load without reset: cycle 30 onward.
  task automatic test_overwrite();
    logic [15:0] act;
    logic        pend;
    while (cyc < 72) begin
      act  = (cyc >= 48) ? 16'h9999 : 16'h1234;
      pend = (cyc >= 31) && (cyc <= 47);
      tests_run++;
      if (pending !== pend) begin
        tests_failed++;
        $display("FAIL ovw_pending cyc=%0d got=%b exp=%b", cyc, pending, pend);
      end
      tests_run++;
      if (bcd_out !== exp_bcd(cyc, act) || an !== exp_an(cyc, act, 1'b0)) begin
        tests_failed++;
        $display("FAIL ovw_disp cyc=%0d bcd=%h an=%b exp bcd=%h an=%b",
                 cyc, bcd_out, an, exp_bcd(cyc, act), exp_an(cyc, act, 1'b0));
      end
      tests_run++;
      if (frame_tick !== exp_tick(cyc)) begin
        tests_failed++;
        $display("FAIL ovw_tick cyc=%0d got=%b exp=%b", cyc, frame_tick, exp_tick(cyc));
      end
      if (cyc == 30) begin
        load = 1'b1;
        dado = 16'h5678;
      end
      if (cyc == 40) begin
        load = 1'b1;
        dado = 16'h9999;
      end
      tick();
      load = 1'b0;
    end
  endtask

  task automatic test_boundary_load();
    logic [15:0] act;
    logic        blz;
    do_reset();
    for (int i = 0; i < 72; i++) begin
      act = (cyc >= 24) ? 16'h0042 : 16'h0000;
      blz = (cyc >= 48);
      tests_run++;
      if (pending !== 1'b0) begin
        tests_failed++;
        $display("FAIL bnd_pending cyc=%0d got=%b exp=0", cyc, pending);
      end
      tests_run++;
      if (bcd_out !== exp_bcd(cyc, act) || an !== exp_an(cyc, act, blz)) begin
        tests_failed++;
        $display("FAIL bnd_disp cyc=%0d bcd=%h an=%b exp bcd=%h an=%b",
                 cyc, bcd_out, an, exp_bcd(cyc, act), exp_an(cyc, act, blz));
      end
      if (cyc == 60) begin
        blank_lz = 1'b0;
        #1;
        tests_run++;
        if (an !== 4'b1011) begin
          tests_failed++;
          $display("FAIL blank_comb cyc=%0d got=%b exp=1011", cyc, an);
        end
        blank_lz = 1'b1;
        #1;
        tests_run++;
        if (an !== 4'b1111) begin
          tests_failed++;
          $display("FAIL blank_comb_back cyc=%0d got=%b exp=1111", cyc, an);
        end
      end
      if (cyc == 23) begin
        load = 1'b1;
        dado = 16'h0042;
      end
      if (cyc == 47) blank_lz = 1'b1;
      tick();
      load = 1'b0;
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_zero_blank();
    do_reset();
    blank_lz = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tests_run++;
      if (an !== exp_an(cyc, 16'h0000, 1'b1) || bcd_out !== 4'h0) begin
        tests_failed++;
        $display("FAIL zero_blank cyc=%0d an=%b bcd=%h exp an=%b bcd=0",
                 cyc, an, bcd_out, exp_an(cyc, 16'h0000, 1'b1));
      end
      tick();
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      if (cyc == 5) begin
        load = 1'b1;
        dado = 16'h1234;
      end
      tick();
      load = 1'b0;
    end
    tests_run++;
    if (pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_pending_before cyc=%0d got=%b exp=1", cyc, pending);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (an !== 4'b1110 || bcd_out !== 4'h0 || pending !== 1'b0 || frame_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_async an=%b bcd=%h pend=%b tick=%b exp an=1110 bcd=0 pend=0 tick=0",
               an, bcd_out, pending, frame_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 30; i++) begin
      tests_run++;
      if (an !== exp_an(cyc, 16'h0000, 1'b0) || bcd_out !== 4'h0 || pending !== 1'b0) begin
        tests_failed++;
        $display("FAIL mid_restart cyc=%0d an=%b bcd=%h pend=%b exp an=%b bcd=0 pend=0",
                 cyc, an, bcd_out, pending, exp_an(cyc, 16'h0000, 1'b0));
      end
      tick();
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    dado     = 16'h0000;
    blank_lz = 1'b0;
    test_reset();
    test_scan();
    test_load();
    test_overwrite();
    test_boundary_load();
    test_zero_blank();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
